// File: rtl/hand_tracker_if.sv
// Sample and result bundle for the hand tracker.
// The producer of proximity samples (master) drives dat_valid/prox_dat and
// observes the filtered paddle outputs; the tracker core is the slave.
interface hand_tracker_if #(
   parameter int DAT_W = 16,
   parameter int POS_W = 9,
   parameter int VEL_W = 8
);
   logic             dat_valid;
   logic [DAT_W-1:0] prox_dat;
   logic [POS_W-1:0] handline;
   logic [VEL_W-1:0] hand_velocity;
   logic             hand_dir;
   logic             out_valid;
   logic             tracking;

   modport master (
      output dat_valid, prox_dat,
      input  handline, hand_velocity, hand_dir, out_valid, tracking
   );

   modport slave (
      input  dat_valid, prox_dat,
      output handline, hand_velocity, hand_dir, out_valid, tracking
   );
endinterface

// File: rtl/hand_tracker.sv
// Hand tracker: turns a noisy proximity sensor stream into a paddle position.
// Samples pass a glitch filter, a moving-average window, an index-to-pixel
// scale with clamp, and finally a velocity/direction stage.
//
// state | meaning
// ------+----------------------------------------------------------------
// FILL  | window not yet full; accepted samples load it, no outputs issued
// TRACK | window full; every accepted sample yields an out_valid 3 cycles on
//
// Pipeline: stage 1 = accept/window (sum register), stage 2 = average,
// scale, clamp (position register), stage 3 = velocity and output registers.
module hand_tracker #(
   parameter int DAT_W      = 16,
   parameter int POS_W      = 9,
   parameter int VEL_W      = 8,
   parameter int LCD_H      = 309,
   parameter int AVG_LOG2   = 2,
   parameter int SHIFT      = 6,
   parameter int IDX_W      = 6,
   parameter int SCALE      = 5,
   parameter int GLITCH_TH  = 16'h0800,
   parameter int MAX_REJECT = 3
) (
   input logic          clk,
   input logic          rst,
   hand_tracker_if.slave bus
);

   localparam int N       = 1 << AVG_LOG2;
   localparam int SUM_W   = DAT_W + AVG_LOG2;
   localparam int FILL_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int REJ_W   = (MAX_REJECT > 0) ? $clog2(MAX_REJECT + 1) : 1;
   localparam int IDX_LSB = SHIFT + AVG_LOG2;
   localparam int DIFF_W  = POS_W + VEL_W;

   localparam logic [DAT_W-1:0]  TH        = DAT_W'(GLITCH_TH);
   localparam logic [REJ_W-1:0]  REJ_MAX   = REJ_W'(MAX_REJECT);
   localparam logic [FILL_W-1:0] FILL_LOAD = FILL_W'(N - 1);
   localparam logic [31:0]       LCD_H_W   = 32'(LCD_H);
   localparam logic [POS_W-1:0]  LCD_H_P   = POS_W'(LCD_H);
   localparam logic [DIFF_W-1:0] VEL_MAX   = DIFF_W'((1 << VEL_W) - 1);

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      TRACK = 1'b1
   } state_t;

   // stage 1: filter and window
   state_t            state;
   logic              have_acc;
   logic [DAT_W-1:0]  last_acc;
   logic [REJ_W-1:0]  rej_cnt;
   logic [FILL_W-1:0] fill_cnt;
   logic [DAT_W-1:0]  win [N];
   logic [SUM_W-1:0]  sum;
   logic              s1_valid;
   logic              track_flag;

   // stage 2: position
   logic              s2_valid;
   logic [POS_W-1:0]  pos2;

   // stage 3: outputs (line_pos doubles as prev_pos for the velocity)
   logic              have_prev;
   logic [POS_W-1:0]  line_pos;
   logic [VEL_W-1:0]  velocity;
   logic              dir_up;
   logic              pulse;

   // combinational helpers
   logic [DAT_W-1:0]  delta;
   logic              accept;
   logic              reject;
   logic [SUM_W-1:0]  sum_next;
   logic [IDX_W-1:0]  idx;
   logic [31:0]       prod;
   logic [POS_W-1:0]  pos_c;
   logic [POS_W-1:0]  pos_diff;
   logic [DIFF_W-1:0] pos_diff_ext;
   logic [VEL_W-1:0]  vel_c;

   // glitch filter decision: an out-of-threshold sample is still taken once
   // MAX_REJECT consecutive rejects have piled up, so a real jump resyncs
   always_comb begin
      delta    = '0;
      accept   = 1'b0;
      reject   = 1'b0;
      sum_next = sum + SUM_W'(bus.prox_dat) - SUM_W'(win[N-1]);
      if (bus.prox_dat >= last_acc) begin
         delta = bus.prox_dat - last_acc;
      end else begin
         delta = last_acc - bus.prox_dat;
      end
      if (bus.dat_valid) begin
         if (!have_acc || (delta < TH) || (rej_cnt == REJ_MAX)) begin
            accept = 1'b1;
         end else begin
            reject = 1'b1;
         end
      end
   end

   // FILL/TRACK sequencing plus the accept/window stage
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         track_flag <= 1'b0;
         have_acc   <= 1'b0;
         last_acc   <= '0;
         rej_cnt    <= '0;
         fill_cnt   <= FILL_LOAD;
         sum        <= '0;
         s1_valid   <= 1'b0;
         for (int i = 0; i < N; i++) begin
            win[i] <= '0;
         end
      end else begin
         s1_valid <= 1'b0;
         if (accept) begin
            have_acc <= 1'b1;
            last_acc <= bus.prox_dat;
            rej_cnt  <= '0;
            sum      <= sum_next;
            win[0]   <= bus.prox_dat;
            for (int i = 1; i < N; i++) begin
               win[i] <= win[i-1];
            end
            case (state)
               FILL: begin
                  if (fill_cnt == '0) begin
                     state      <= TRACK;
                     track_flag <= 1'b1;
                     s1_valid   <= 1'b1;
                  end else begin
                     fill_cnt <= fill_cnt - 1'b1;
                  end
               end
               TRACK: begin
                  s1_valid <= 1'b1;
               end
               default: begin
                  state      <= FILL;
                  track_flag <= 1'b0;
               end
            endcase
         end else if (reject) begin
            rej_cnt <= rej_cnt + 1'b1;
         end
      end
   end

   // average is a plain bit-select of the sum; product kept wide for the clamp
   always_comb begin
      idx   = sum[IDX_LSB +: IDX_W];
      prod  = 32'(idx) * 32'(SCALE);
      pos_c = POS_W'(prod);
      if (prod > LCD_H_W) begin
         pos_c = LCD_H_P;
      end
   end

   // stage 2: register the scaled, clamped position
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         pos2     <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            pos2 <= pos_c;
         end
      end
   end

   // magnitude of the position step, saturated to the velocity width
   always_comb begin
      pos_diff = '0;
      if (pos2 > line_pos) begin
         pos_diff = pos2 - line_pos;
      end else begin
         pos_diff = line_pos - pos2;
      end
      pos_diff_ext = DIFF_W'(pos_diff);
      vel_c        = VEL_W'(pos_diff_ext);
      if (pos_diff_ext > VEL_MAX) begin
         vel_c = '1;
      end
   end

   // stage 3: output registers; the first result after fill seeds prev_pos
   always_ff @(posedge clk) begin
      if (rst) begin
         have_prev <= 1'b0;
         line_pos  <= '0;
         velocity  <= '0;
         dir_up    <= 1'b0;
         pulse     <= 1'b0;
      end else begin
         pulse <= s2_valid;
         if (s2_valid) begin
            have_prev <= 1'b1;
            line_pos  <= pos2;
            if (have_prev) begin
               velocity <= vel_c;
               dir_up   <= (pos2 > line_pos);
            end else begin
               velocity <= '0;
               dir_up   <= 1'b0;
            end
         end
      end
   end

   assign bus.handline      = line_pos;
   assign bus.hand_velocity = velocity;
   assign bus.hand_dir      = dir_up;
   assign bus.out_valid     = pulse;
   assign bus.tracking      = track_flag;

endmodule

// File: tb/tb_hand_tracker.sv
// Bench for hand_tracker: directed scenarios followed by random traffic.
// Expected results come from a windowed-mean reference model and are queued
// with the cycle they are due; a negedge monitor compares every cycle.
module tb_hand_tracker;

   localparam int DAT_W      = 16;
   localparam int POS_W      = 9;
   localparam int VEL_W      = 8;
   localparam int LCD_H      = 309;
   localparam int AVG_LOG2   = 2;
   localparam int SHIFT      = 6;
   localparam int IDX_W      = 6;
   localparam int SCALE      = 5;
   localparam int GLITCH_TH  = 16'h0800;
   localparam int MAX_REJECT = 3;
   localparam int N          = 1 << AVG_LOG2;
   localparam int VEL_MAX    = (1 << VEL_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   hand_tracker_if #(.DAT_W(DAT_W), .POS_W(POS_W), .VEL_W(VEL_W)) bus ();

   hand_tracker #(
      .DAT_W(DAT_W), .POS_W(POS_W), .VEL_W(VEL_W), .LCD_H(LCD_H),
      .AVG_LOG2(AVG_LOG2), .SHIFT(SHIFT), .IDX_W(IDX_W), .SCALE(SCALE),
      .GLITCH_TH(GLITCH_TH), .MAX_REJECT(MAX_REJECT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int due;
      bit is_rst;
      int pos;
      int vel;
      bit dir;
   } exp_t;

   typedef struct {
      int due;
      bit val;
   } trk_t;

   exp_t oq[$];
   trk_t tq[$];

   // reference model state
   bit   m_have;
   int   m_last;
   int   m_rej;
   int   m_win[$];
   int   m_cnt;
   bit   m_have_prev;
   int   m_prev;

   // values the DUT must be holding right now
   int   h_pos, h_vel;
   bit   h_dir, h_trk;
   bit   mon_en = 1'b0;
   exp_t e;
   bit   ov_exp;

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic model_reset(input int k);
      m_have = 0; m_last = 0; m_rej = 0; m_cnt = 0;
      m_have_prev = 0; m_prev = 0;
      m_win.delete();
      while (oq.size() > 0 && oq[oq.size()-1].due > k) void'(oq.pop_back());
      while (tq.size() > 0 && tq[tq.size()-1].due > k) void'(tq.pop_back());
      oq.push_back('{due: k + 1, is_rst: 1'b1, pos: 0, vel: 0, dir: 1'b0});
      tq.push_back('{due: k + 1, val: 1'b0});
   endtask

   task automatic model_sample(input int k, input int d);
      int diff, sum, avg, idx, pos, vel;
      bit dir;
      diff = d - m_last;
      if (diff < 0) diff = -diff;
      if (m_have && diff >= GLITCH_TH && m_rej < MAX_REJECT) begin
         m_rej++;
         return;
      end
      m_rej  = 0;
      m_have = 1;
      m_last = d;
      m_win.push_back(d);
      if (m_win.size() > N) void'(m_win.pop_front());
      m_cnt++;
      if (m_cnt == N) tq.push_back('{due: k + 1, val: 1'b1});
      if (m_cnt >= N) begin
         sum = 0;
         foreach (m_win[i]) sum += m_win[i];
         avg = sum / N;
         idx = (avg / (1 << SHIFT)) % (1 << IDX_W);
         pos = idx * SCALE;
         if (pos > LCD_H) pos = LCD_H;
         vel = 0;
         dir = 1'b0;
         if (m_have_prev) begin
            vel = (pos > m_prev) ? pos - m_prev : m_prev - pos;
            if (vel > VEL_MAX) vel = VEL_MAX;
            dir = (pos > m_prev);
         end
         m_prev = pos;
         m_have_prev = 1;
         oq.push_back('{due: k + 3, is_rst: 1'b0, pos: pos, vel: vel, dir: dir});
      end
   endtask

   // one clock of stimulus; inputs change just after the rising edge
   task automatic step(input bit v, input int d, input bit r);
      @(posedge clk);
      #1;
      rst           = r;
      bus.dat_valid = v;
      bus.prox_dat  = 16'(d);
      if (r) model_reset(cyc);
      else if (v) model_sample(cyc, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
   endtask

   task automatic sample(input int d);
      step(1'b1, d, 1'b0);
   endtask

   // scoreboard monitor: pops the entry due this cycle and checks all outputs
   always @(negedge clk) begin
      if (mon_en) begin
         ov_exp = 1'b0;
         while (tq.size() > 0 && tq[0].due <= cyc) begin
            h_trk = tq[0].val;
            void'(tq.pop_front());
         end
         if (oq.size() > 0 && oq[0].due <= cyc) begin
            e = oq.pop_front();
            h_pos = e.pos;
            h_vel = e.vel;
            h_dir = e.dir;
            ov_exp = !e.is_rst;
         end
         check("out_valid", int'(bus.out_valid), int'(ov_exp));
         check("handline", int'(bus.handline), h_pos);
         check("hand_velocity", int'(bus.hand_velocity), h_vel);
         check("hand_dir", int'(bus.hand_dir), int'(h_dir));
         check("tracking", int'(bus.tracking), int'(h_trk));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int d, base;
      int r;
      bus.dat_valid = 1'b0;
      bus.prox_dat  = '0;
      repeat (3) step(1'b0, 0, 1'b1);
      oq.delete();
      tq.delete();
      h_pos = 0; h_vel = 0; h_dir = 1'b0; h_trk = 1'b0;
      mon_en = 1'b1;
      check("reset_handline", int'(bus.handline), 0);
      check("reset_out_valid", int'(bus.out_valid), 0);
      check("reset_tracking", int'(bus.tracking), 0);

      // fill
      repeat (4) sample(16'h0400);
      idle(4);
      check("fill_handline", int'(bus.handline), 80);
      check("fill_velocity", int'(bus.hand_velocity), 0);
      check("fill_tracking", int'(bus.tracking), 1);

      // single glitch at exactly the threshold distance
      sample(16'h0C00);
      idle(4);
      check("glitch_hold", int'(bus.handline), 80);
      sample(16'h0400);
      idle(4);
      check("glitch_after", int'(bus.handline), 80);

      // resync after repeated far samples
      repeat (4) begin
         sample(16'h0C00);
         idle(1);
      end
      idle(3);
      check("resync_handline", int'(bus.handline), 120);
      check("resync_velocity", int'(bus.hand_velocity), 40);
      check("resync_dir", int'(bus.hand_dir), 1);

      // back-to-back throughput
      for (int i = 1; i <= 8; i++) sample(16'h0C00 + i * 16'h0040);
      idle(4);

      // reset right after an accepted sample, then rst coincident with a sample
      sample(m_last + 16'h0040);
      step(1'b0, 0, 1'b1);
      step(1'b1, 16'h0400, 1'b1);
      idle(5);
      check("rstmid_handline", int'(bus.handline), 0);
      check("rstmid_tracking", int'(bus.tracking), 0);
      repeat (3) sample(16'h0400);
      idle(3);
      check("refill_tracking_low", int'(bus.tracking), 0);
      sample(16'h0400);
      idle(1);
      check("refill_tracking_high", int'(bus.tracking), 1);
      idle(3);

      // clamp, then index wrap forcing velocity saturation
      idle(1);
      step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b1);
      repeat (4) sample(16'h0FC0);
      idle(4);
      check("clamp_handline", int'(bus.handline), 309);
      sample(16'h1100);
      idle(4);
      check("sat_velocity", int'(bus.hand_velocity), 255);
      check("sat_dir", int'(bus.hand_dir), 0);
      sample(16'h1100 + 16'h07FF);
      sample(16'h1100 + 16'h07FF + 16'h0800);
      idle(4);

      // random traffic with gaps, glitches and occasional resets
      for (int n = 0; n < 700; n++) begin
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            step(1'b0, 0, 1'b1);
         end else if (r < 4) begin
            step(1'b1, int'($urandom_range(0, 16'hFFFF)), 1'b1);
         end else if (r < 65) begin
            if ($urandom_range(0, 9) == 0) begin
               d = int'($urandom_range(0, 16'hFFFF));
            end else begin
               base = m_have ? m_last : int'($urandom_range(0, 16'h0FFF));
               d = base + int'($urandom_range(0, 16'h1000)) - 16'h0800;
               if (d < 0) d = 0;
               if (d > 16'hFFFF) d = 16'hFFFF;
            end
            sample(d);
         end else begin
            idle(1);
         end
      end
      idle(6);
      check("queue_drained", oq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hand_tracker.md
HAND_TRACKER -- requirements
Module: hand_tracker

Interface
REQ-001 SHALL provide parameter DAT_W, default 16: sensor sample width.
REQ-002 SHALL provide parameter POS_W, default 9: paddle position width.
REQ-003 SHALL provide parameter VEL_W, default 8: velocity magnitude width.
REQ-004 SHALL provide parameter LCD_H, default 309: maximum legal position.
REQ-005 SHALL provide parameter AVG_LOG2, default 2: moving-average window is 2^AVG_LOG2 samples.
REQ-006 SHALL provide parameter SHIFT, default 6: LSB of the position index field in the averaged sample.
REQ-007 SHALL provide parameter IDX_W, default 6: position index field width.
REQ-008 SHALL provide parameter SCALE, default 5: index-to-pixel multiplier.
REQ-009 SHALL provide parameter GLITCH_TH, default 16'h0800: rejection threshold.
REQ-010 SHALL provide parameter MAX_REJECT, default 3: consecutive rejects tolerated before resync.
REQ-011 SHALL provide port clk, input, 1: single clock; all logic on its rising edge.
REQ-012 SHALL provide port rst, input, 1: synchronous, active-high reset.
REQ-013 SHALL provide port dat_valid, input, 1: single-cycle sample strobe, synchronous to clk.
REQ-014 SHALL provide port prox_dat, input, DAT_W: proximity sample, qualified by dat_valid.
REQ-015 SHALL provide port handline, output, POS_W: filtered paddle position.
REQ-016 SHALL provide port hand_velocity, output, VEL_W: |position delta| per accepted output.
REQ-017 SHALL provide port hand_dir, output, 1: 1 when position increased, 0 otherwise.
REQ-018 SHALL provide port out_valid, output, 1: one-cycle pulse when handline, hand_velocity and hand_dir update.
REQ-019 SHALL provide port tracking, output, 1: high while in TRACK state.

Function
REQ-020 SHALL implement states FILL and TRACK; reset enters FILL.
REQ-021 In both states, the first sample after reset SHALL be accepted unconditionally and recorded as last_acc.
REQ-022 In both states, any later sample SHALL be rejected when |prox_dat - last_acc| >= GLITCH_TH; otherwise it SHALL be accepted.
- Rejected samples do not update the window, last_acc, or outputs, and produce no out_valid.
- Each rejection increments rej_cnt.
REQ-023 When rej_cnt == MAX_REJECT and another out-of-threshold sample arrives, that sample SHALL be accepted (resync) and rej_cnt SHALL clear.
REQ-024 Any accepted sample SHALL clear rej_cnt, update last_acc, and shift into the window.
REQ-025 The window sum SHALL be DAT_W+AVG_LOG2 bits wide, with no overflow.
- avg = sum >> AVG_LOG2.
REQ-026 Position SHALL be computed from the averaged sample:
- idx = avg[SHIFT+IDX_W-1:SHIFT].
- pos = idx*SCALE, computed at full width.
- pos > LCD_H SHALL yield LCD_H.
- idx == 0 SHALL yield 0.
REQ-027 FILL SHALL transition to TRACK on the 2^AVG_LOG2-th accepted sample; no out_valid SHALL be issued in FILL.
REQ-028 out_valid SHALL pulse exactly 3 clk cycles after the dat_valid of each accepted sample in TRACK (including the transitioning sample).
REQ-029 The datapath SHALL be pipelined over 3 stages: accept/window, average/scale/clamp, velocity/output register.
- It SHALL accept dat_valid on every cycle, back-to-back, without loss.
REQ-030 hand_velocity SHALL be |pos - prev_pos| saturated to 2^VEL_W-1.
- hand_dir = (pos > prev_pos).
- prev_pos updates on every out_valid.
REQ-031 The first out_valid after FILL SHALL report velocity 0 and hand_dir 0.
- prev_pos is seeded with that first pos.
REQ-032 handline, hand_velocity and hand_dir SHALL hold their values between out_valid pulses.

Reset
REQ-033 rst SHALL clear handline, hand_velocity, hand_dir, out_valid, tracking, rej_cnt, window, sum, last_acc, prev_pos and all pipeline valids to 0; the state SHALL return to FILL.
REQ-034 rst asserted mid-pipeline SHALL discard in-flight samples: no out_valid in the cycles after rst deasserts until a new fill completes.
REQ-035 rst SHALL take priority over a coincident dat_valid.

Verification
REQ-036 Fill: after reset, send 4 samples of 16'h0400 -> a single out_valid 3 cycles after the 4th; handline=80, hand_velocity=0, tracking=1.
REQ-037 Clamp: after reset, send 4 samples of 16'h0FC0 -> handline=309 (idx 63*5=315 clamped).
REQ-038 Glitch: in steady 16'h0400 tracking, send one 16'h0C00 -> no out_valid; handline stays 80. Then send 16'h0400 -> out_valid, handline=80, velocity 0.
REQ-039 Resync: in steady 16'h0400, send four 16'h0C00 -> the first 3 produce no out_valid; the 4th yields handline=120, hand_velocity=40, hand_dir=1.
REQ-040 Throughput: send 8 back-to-back dat_valid on consecutive cycles in TRACK -> 8 consecutive out_valid pulses, each 3 cycles after its sample.
REQ-041 Reset mid-op: assert rst 1 cycle after an accepted sample in TRACK -> no out_valid follows; all outputs 0; tracking=0 until 4 new accepted samples.
